// File: rtl/axil_lat_ram.sv
// axil_lat_ram
//   AXI4-Lite slave RAM with independent one-entry AW/W holding registers,
//   a fixed read latency of READ_LATENCY cycles (1..4) and DECERR responses
//   for word indices at or beyond MEM_WORDS. Memory contents survive reset.
//
//   Optional feature macro: AXIL_LAT_RAM_DEBUG_EN
//     When defined, adds a combinational peek port (debug_addr/debug_data)
//     and a backdoor word write port (debug_wr_addr/debug_wr_data/debug_wr_en).
//
// Ports
//   clk, rst                 clock (posedge) and synchronous active-high reset
//   debug_*                  backdoor peek/write (only with AXIL_LAT_RAM_DEBUG_EN)
//   s_axil_aw*/w*/b*         AXI4-Lite write address, data and response channels
//   s_axil_ar*/r*            AXI4-Lite read address and data channels
//   (awprot/arprot are accepted and ignored)
module axil_lat_ram #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int MEM_WORDS    = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef AXIL_LAT_RAM_DEBUG_EN
    input  logic [ADDR_WIDTH-1:0] debug_addr,
    output logic [DATA_WIDTH-1:0] debug_data,
    input  logic [ADDR_WIDTH-1:0] debug_wr_addr,
    input  logic [DATA_WIDTH-1:0] debug_wr_data,
    input  logic                  debug_wr_en,
`endif
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready
);

    localparam int ADDR_LSB = $clog2(STRB_WIDTH);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam int MEM_AW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    // One extra bit so MEM_WORDS == 2^IDX_W is representable.
    localparam logic [IDX_W:0] MEM_LIMIT = (IDX_W + 1)'(MEM_WORDS);
    localparam logic [1:0]     LAT_LAST  = 2'(READ_LATENCY - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_BUSY,
        RD_RESP
    } rd_state_e;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    // Write-side state
    logic                  aw_held_q, aw_held_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic                  w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;

    // Read-side state
    rd_state_e             state_q, state_d;
    logic [1:0]            lat_cnt_q, lat_cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic                  wr_commit;
    logic                  wr_in_range;
    logic                  mem_we;
    logic [IDX_W-1:0]      ar_idx;
    logic                  ar_in_range;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_inputs;

    assign unused_inputs = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr};

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    assign s_axil_awready = !aw_held_q;
    assign s_axil_wready  = !w_held_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;

    assign wr_in_range = {1'b0, aw_idx_q} < MEM_LIMIT;
    // A commit may overlap the B handshake of the previous response.
    assign wr_commit   = aw_held_q && w_held_q && (!bvalid_q || s_axil_bready);
    assign mem_we      = wr_commit && wr_in_range && !rst;

    always_comb begin
        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;

        if (bvalid_q && s_axil_bready) begin
            bvalid_d = 1'b0;
        end

        if (wr_commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_in_range ? RESP_OKAY : RESP_DECERR;
        end

        if (s_axil_awvalid && !aw_held_q) begin
            aw_held_d = 1'b1;
            aw_idx_d  = s_axil_awaddr[ADDR_WIDTH-1:ADDR_LSB];
        end

        if (s_axil_wvalid && !w_held_q) begin
            w_held_d = 1'b1;
            w_data_d = s_axil_wdata;
            w_strb_d = s_axil_wstrb;
        end
    end

    // ------------------------------------------------------------------
    // Memory array (never reset)
    // ------------------------------------------------------------------
`ifdef AXIL_LAT_RAM_DEBUG_EN
    localparam logic [ADDR_WIDTH:0] DBG_LIMIT = (ADDR_WIDTH + 1)'(MEM_WORDS);

    logic dbg_rd_in_range;
    logic dbg_wr_in_range;
    logic dbg_we;

    assign dbg_rd_in_range = {1'b0, debug_addr} < DBG_LIMIT;
    assign dbg_wr_in_range = {1'b0, debug_wr_addr} < DBG_LIMIT;
    assign debug_data      = dbg_rd_in_range ? mem[debug_addr[MEM_AW-1:0]] : '0;

    // A backdoor write to the word an AXI commit targets is dropped entirely.
    assign dbg_we = debug_wr_en && dbg_wr_in_range &&
                    !(mem_we && (aw_idx_q[MEM_AW-1:0] == debug_wr_addr[MEM_AW-1:0]));

    always_ff @(posedge clk) begin
        if (dbg_we) begin
            mem[debug_wr_addr[MEM_AW-1:0]] <= debug_wr_data;
        end
        if (mem_we) begin
            for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
                if (w_strb_q[i]) begin
                    mem[aw_idx_q[MEM_AW-1:0]][i*8 +: 8] <= w_data_q[i*8 +: 8];
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
                if (w_strb_q[i]) begin
                    mem[aw_idx_q[MEM_AW-1:0]][i*8 +: 8] <= w_data_q[i*8 +: 8];
                end
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    assign ar_idx      = s_axil_araddr[ADDR_WIDTH-1:ADDR_LSB];
    assign ar_in_range = {1'b0, ar_idx} < MEM_LIMIT;
    assign rd_word     = mem[ar_idx[MEM_AW-1:0]];

    assign s_axil_arready = (state_q == RD_IDLE);
    assign s_axil_rvalid  = (state_q == RD_RESP);
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;

    // The word is sampled at the AR handshake, before any same-edge write
    // lands, so a colliding read returns the old contents. BUSY then lasts
    // READ_LATENCY cycles so rvalid rises READ_LATENCY edges after AR.
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        unique case (state_q)
            RD_IDLE: begin
                if (s_axil_arvalid) begin
                    rdata_d   = ar_in_range ? rd_word : '0;
                    rresp_d   = ar_in_range ? RESP_OKAY : RESP_DECERR;
                    lat_cnt_d = '0;
                    state_d   = RD_BUSY;
                end
            end
            RD_BUSY: begin
                if (lat_cnt_q == LAT_LAST) begin
                    state_d = RD_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            RD_RESP: begin
                if (s_axil_rready) begin
                    state_d = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            state_q   <= RD_IDLE;
            lat_cnt_q <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

endmodule

// File: tb/tb_axil_lat_ram.sv
// tb_axil_lat_ram
//   Randomized scoreboard bench for axil_lat_ram (READ_LATENCY=3,
//   MEM_WORDS=1024). The driver updates a word-array reference model and
//   queues the expected B/R responses; a negedge monitor pops and compares
//   them at every handshake. Timing properties are checked inline.
module tb_axil_lat_ram;

    localparam int DW        = 32;
    localparam int AW        = 16;
    localparam int MEM_WORDS = 1024;
    localparam int LAT       = 3;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] s_axil_awaddr;
    logic [2:0]    s_axil_awprot;
    logic          s_axil_awvalid;
    logic          s_axil_awready;
    logic [DW-1:0] s_axil_wdata;
    logic [3:0]    s_axil_wstrb;
    logic          s_axil_wvalid;
    logic          s_axil_wready;
    logic [1:0]    s_axil_bresp;
    logic          s_axil_bvalid;
    logic          s_axil_bready;
    logic [AW-1:0] s_axil_araddr;
    logic [2:0]    s_axil_arprot;
    logic          s_axil_arvalid;
    logic          s_axil_arready;
    logic [DW-1:0] s_axil_rdata;
    logic [1:0]    s_axil_rresp;
    logic          s_axil_rvalid;
    logic          s_axil_rready;
`ifdef AXIL_LAT_RAM_DEBUG_EN
    logic [AW-1:0] debug_addr;
    logic [DW-1:0] debug_data;
    logic [AW-1:0] debug_wr_addr;
    logic [DW-1:0] debug_wr_data;
    logic          debug_wr_en;
`endif

    int   checks = 0;
    int   errors = 0;
    rsp_t b_q[$];
    rsp_t r_q[$];
    rsp_t be, re;
    logic [31:0] model_mem [MEM_WORDS];

    always #5 clk = ~clk;

    axil_lat_ram #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .MEM_WORDS   (MEM_WORDS),
        .READ_LATENCY(LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef AXIL_LAT_RAM_DEBUG_EN
        .debug_addr    (debug_addr),
        .debug_data    (debug_data),
        .debug_wr_addr (debug_wr_addr),
        .debug_wr_data (debug_wr_data),
        .debug_wr_en   (debug_wr_en),
`endif
        .s_axil_awaddr (s_axil_awaddr),
        .s_axil_awprot (s_axil_awprot),
        .s_axil_awvalid(s_axil_awvalid),
        .s_axil_awready(s_axil_awready),
        .s_axil_wdata  (s_axil_wdata),
        .s_axil_wstrb  (s_axil_wstrb),
        .s_axil_wvalid (s_axil_wvalid),
        .s_axil_wready (s_axil_wready),
        .s_axil_bresp  (s_axil_bresp),
        .s_axil_bvalid (s_axil_bvalid),
        .s_axil_bready (s_axil_bready),
        .s_axil_araddr (s_axil_araddr),
        .s_axil_arprot (s_axil_arprot),
        .s_axil_arvalid(s_axil_arvalid),
        .s_axil_arready(s_axil_arready),
        .s_axil_rdata  (s_axil_rdata),
        .s_axil_rresp  (s_axil_rresp),
        .s_axil_rvalid (s_axil_rvalid),
        .s_axil_rready (s_axil_rready)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: actual timeout required handshake", name);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: byte-addressed words, index = byte address / 4.
    task automatic model_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int   idx;
        rsp_t e;
        idx    = int'(addr) / 4;
        e.data = '0;
        if (idx < MEM_WORDS) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model_mem[idx][b*8 +: 8] = data[b*8 +: 8];
            e.resp = 2'b00;
        end else begin
            e.resp = 2'b11;
        end
        b_q.push_back(e);
    endtask

    task automatic model_read(input logic [15:0] addr);
        int   idx;
        rsp_t e;
        idx = int'(addr) / 4;
        if (idx < MEM_WORDS) begin
            e.resp = 2'b00;
            e.data = model_mem[idx];
        end else begin
            e.resp = 2'b11;
            e.data = '0;
        end
        r_q.push_back(e);
    endtask

    // Monitor: compare every completed B and R handshake against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (s_axil_bvalid && s_axil_bready) begin
                if (b_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected: actual bresp=%0d required no response", s_axil_bresp);
                end else begin
                    be = b_q.pop_front();
                    chk("bresp", 32'(s_axil_bresp), 32'(be.resp));
                end
            end
            if (s_axil_rvalid && s_axil_rready) begin
                if (r_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL r_unexpected: actual rdata=0x%0h required no response", s_axil_rdata);
                end else begin
                    re = r_q.pop_front();
                    chk("rresp", 32'(s_axil_rresp), 32'(re.resp));
                    chk("rdata", s_axil_rdata, re.data);
                end
            end
        end
    end

    // lead > 0: W goes first, AW lead cycles after W is taken; lead < 0: the reverse.
    task automatic axi_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int lead, input int bdelay, input bit wait_b);
        int n;
        bit aw_done, w_done, aw_hs, w_hs, hs;
        model_write(addr, data, strb);
        aw_done = 1'b0;
        w_done  = 1'b0;
        n       = 0;
        if (wait_b) s_axil_bready = (bdelay == 0);
        s_axil_awaddr  = addr;
        s_axil_wdata   = data;
        s_axil_wstrb   = strb;
        s_axil_awvalid = (lead <= 0);
        s_axil_wvalid  = (lead >= 0);
        while (!(aw_done && w_done) && n < 40) begin
            @(negedge clk);
            aw_hs = s_axil_awvalid && s_axil_awready;
            w_hs  = s_axil_wvalid && s_axil_wready;
            tick();
            n++;
            if (aw_hs) begin aw_done = 1'b1; s_axil_awvalid = 1'b0; end
            if (w_hs)  begin w_done  = 1'b1; s_axil_wvalid  = 1'b0; end
            if (w_done && !aw_done)  chk("wready_held", 32'(s_axil_wready), 0);
            if (aw_done && !w_done)  chk("awready_held", 32'(s_axil_awready), 0);
            if (w_done && !aw_done && !s_axil_awvalid && n >= lead)  s_axil_awvalid = 1'b1;
            if (aw_done && !w_done && !s_axil_wvalid && n >= -lead)  s_axil_wvalid  = 1'b1;
        end
        if (!(aw_done && w_done)) begin
            fail_timeout("aw_w_handshake");
            s_axil_awvalid = 1'b0;
            s_axil_wvalid  = 1'b0;
            return;
        end
        if (!wait_b) return;
        chk("bvalid_after_hs", 32'(s_axil_bvalid), 0);
        chk("awready_after_hs", 32'(s_axil_awready), 0);
        chk("wready_after_hs", 32'(s_axil_wready), 0);
        tick();
        chk("bvalid_commit", 32'(s_axil_bvalid), 1);
        chk("awready_commit", 32'(s_axil_awready), 1);
        chk("wready_commit", 32'(s_axil_wready), 1);
        repeat (bdelay) begin
            tick();
            chk("bvalid_hold", 32'(s_axil_bvalid), 1);
        end
        s_axil_bready = 1'b1;
        n  = 0;
        hs = 1'b0;
        while (!hs && n < 20) begin
            @(negedge clk);
            hs = s_axil_bvalid && s_axil_bready;
            tick();
            n++;
        end
        if (!hs) fail_timeout("b_handshake");
    endtask

    task automatic axi_read(input logic [15:0] addr, input int rdelay, output logic [31:0] got);
        int n;
        bit hs;
        model_read(addr);
        got            = '0;
        s_axil_rready  = (rdelay == 0);
        s_axil_araddr  = addr;
        s_axil_arvalid = 1'b1;
        n  = 0;
        hs = 1'b0;
        while (!hs && n < 40) begin
            @(negedge clk);
            hs = s_axil_arvalid && s_axil_arready;
            tick();
            n++;
        end
        s_axil_arvalid = 1'b0;
        if (!hs) begin
            fail_timeout("ar_handshake");
            return;
        end
        n = 0;
        while (!s_axil_rvalid && n < 10) begin
            chk("arready_busy", 32'(s_axil_arready), 0);
            tick();
            n++;
        end
        chk("rd_latency", 32'(n), 32'(LAT));
        got = s_axil_rdata;
        repeat (rdelay) begin
            tick();
            chk("rvalid_hold", 32'(s_axil_rvalid), 1);
            chk("rdata_stable", s_axil_rdata, got);
            chk("arready_resp", 32'(s_axil_arready), 0);
        end
        s_axil_rready = 1'b1;
        n  = 0;
        hs = 1'b0;
        while (!hs && n < 20) begin
            @(negedge clk);
            hs = s_axil_rvalid && s_axil_rready;
            tick();
            n++;
        end
        if (!hs) begin
            fail_timeout("r_handshake");
            return;
        end
        chk("arready_after_r", 32'(s_axil_arready), 1);
        chk("rvalid_after_r", 32'(s_axil_rvalid), 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((b_q.size() != 0 || r_q.size() != 0) && n < 50) begin
            tick();
            n++;
        end
        if (b_q.size() != 0 || r_q.size() != 0) fail_timeout("drain");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual still running required completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        logic [15:0] addr;

        rst            = 1'b1;
        s_axil_awaddr  = '0;
        s_axil_awprot  = '0;
        s_axil_awvalid = 1'b0;
        s_axil_wdata   = '0;
        s_axil_wstrb   = '0;
        s_axil_wvalid  = 1'b0;
        s_axil_bready  = 1'b1;
        s_axil_araddr  = '0;
        s_axil_arprot  = '0;
        s_axil_arvalid = 1'b0;
        s_axil_rready  = 1'b1;
`ifdef AXIL_LAT_RAM_DEBUG_EN
        debug_addr    = 16'd2;
        debug_wr_addr = '0;
        debug_wr_data = '0;
        debug_wr_en   = 1'b0;
`endif

        // Reset state after two edges with rst high
        tick();
        tick();
        chk("rst_awready", 32'(s_axil_awready), 1);
        chk("rst_wready", 32'(s_axil_wready), 1);
        chk("rst_arready", 32'(s_axil_arready), 1);
        chk("rst_bvalid", 32'(s_axil_bvalid), 0);
        chk("rst_rvalid", 32'(s_axil_rvalid), 0);
        chk("rst_bresp", 32'(s_axil_bresp), 0);
        chk("rst_rresp", 32'(s_axil_rresp), 0);
        chk("rst_rdata", s_axil_rdata, 0);
        rst = 1'b0;
        tick();

        // Give words 0..15 known contents
        for (int w = 0; w < 16; w++) axi_write(16'(w * 4), $urandom, 4'hF, 0, 0, 1);

        // Partial-strobe write over a preloaded word
        axi_write(16'h0008, 32'h11111111, 4'hF, 0, 0, 1);
        axi_write(16'h0008, 32'hDEADBEEF, 4'b0101, 0, 0, 1);
`ifdef AXIL_LAT_RAM_DEBUG_EN
        chk("debug_peek", debug_data, 32'h11AD11EF);
`endif
        axi_read(16'h0008, 4, got);
        chk("word2_value", got, 32'h11AD11EF);

        // W three cycles ahead of AW
        axi_write(16'h000C, 32'hCAFEF00D, 4'hF, 3, 0, 1);
        axi_read(16'h000C, 0, got);

        // Out-of-range write and read; word 0 must be untouched by aliasing
        axi_write(16'h1000, 32'hA5A5A5A5, 4'hF, 0, 1, 1);
        axi_read(16'h1000, 0, got);
        axi_read(16'h0000, 0, got);

        // Read and write commit to the same word on the same edge
        model_read(16'd20);
        model_write(16'd20, 32'h0BADF00D, 4'hF);
        s_axil_awaddr  = 16'd20;
        s_axil_wdata   = 32'h0BADF00D;
        s_axil_wstrb   = 4'hF;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        tick();
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        chk("collide_aw_taken", 32'(s_axil_awready), 0);
        s_axil_araddr  = 16'd20;
        s_axil_arvalid = 1'b1;
        tick();
        s_axil_arvalid = 1'b0;
        chk("collide_ar_taken", 32'(s_axil_arready), 0);
        drain();
        axi_read(16'd20, 0, got);

        // B back-pressure: second write waits in the holds until bready
        s_axil_bready = 1'b0;
        axi_write(16'd24, 32'h12345678, 4'hF, 0, 0, 0);
        tick();
        chk("bp_bvalid", 32'(s_axil_bvalid), 1);
        axi_write(16'd28, 32'h9ABCDEF0, 4'b1100, 0, 0, 0);
        repeat (2) begin
            tick();
            chk("bp_bvalid_hold", 32'(s_axil_bvalid), 1);
            chk("bp_holds_full", 32'(s_axil_awready), 0);
        end
        s_axil_bready = 1'b1;
        tick();
        chk("bp_second_bvalid", 32'(s_axil_bvalid), 1);
        chk("bp_holds_free", 32'(s_axil_awready), 1);
        tick();
        chk("bp_done", 32'(s_axil_bvalid), 0);
        drain();
        axi_read(16'd24, 0, got);
        axi_read(16'd28, 1, got);

        // Reset while the read is in BUSY: no response, next read is normal
        s_axil_araddr  = 16'd8;
        s_axil_arvalid = 1'b1;
        tick();
        s_axil_arvalid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy_arready", 32'(s_axil_arready), 1);
        repeat (LAT + 2) begin
            tick();
            chk("rst_busy_no_rvalid", 32'(s_axil_rvalid), 0);
        end
        axi_read(16'd8, 1, got);

        // Randomized traffic
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 4) == 0)
                addr = 16'(32'h1000 + $urandom_range(0, 32'hEFFF));
            else
                addr = 16'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                axi_write(addr, $urandom, 4'($urandom), int'($urandom_range(0, 6)) - 3,
                          int'($urandom_range(0, 2)), 1);
            else
                axi_read(addr, int'($urandom_range(0, 2)), got);
        end

        drain();
        chk("b_queue_empty", 32'(b_q.size()), 0);
        chk("r_queue_empty", 32'(r_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
